// File: rtl/tx_uart_fifo.sv
// Framed UART transmitter (DATA_BITS, optional parity, 1/2 stop bits) fed by a small FIFO.
// Define TX_UART_BREAK_EN to add the brk input, which holds the idle line low as a break.
module tx_uart_fifo #(
  parameter int unsigned SYSTEM_CLK = 100_000_000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        ready,
  input  logic                        div_we,
  input  logic [DIV_WIDTH-1:0]        div_in,
`ifdef TX_UART_BREAK_EN
  input  logic                        brk,
`endif
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DIV_RAW = SYSTEM_CLK / BAUDRATE;
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'((DIV_RAW < 2) ? 2 : DIV_RAW);
  localparam logic PAR_ODD = 1'(PARITY == 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign ready      = !full;
  assign push       = valid && !full;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Baud divisor register
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      divisor <= DIV_RESET;
    end else if (div_we) begin
      divisor <= (div_in < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Line break hold
  // ---------------------------------------------------------------------------
  logic brk_hold;

`ifdef TX_UART_BREAK_EN
  assign brk_hold = brk;
`else
  assign brk_hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  state_e               state;
  logic [DIV_WIDTH-1:0] cur_div;
  logic [DIV_WIDTH-1:0] bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 sym_end;
  logic                 frame_end;

  assign sym_end   = (bit_cnt == '0);
  assign frame_end = (state == StStop) && sym_end && (bit_idx == IDX_W'(STOP_BITS - 1));
  // A pop doubles as the frame start, so back-to-back frames have no idle gap.
  assign pop       = !empty && !brk_hold && ((state == StIdle) || frame_end);
  assign busy      = (state != StIdle) || !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      tx_out  <= 1'b1;
      cur_div <= DIV_RESET;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (pop) begin
      state   <= StStart;
      tx_out  <= 1'b0;
      cur_div <= divisor;
      bit_cnt <= divisor - DIV_WIDTH'(1);
      bit_idx <= '0;
      shift   <= mem[rd_ptr];
      par_bit <= (^mem[rd_ptr]) ^ PAR_ODD;
    end else begin
      case (state)
        StIdle: begin
          tx_out <= !brk_hold;
        end
        StStart: begin
          if (sym_end) begin
            state   <= StData;
            tx_out  <= shift[0];
            bit_cnt <= cur_div - DIV_WIDTH'(1);
          end else begin
            bit_cnt <= bit_cnt - DIV_WIDTH'(1);
          end
        end
        StData: begin
          if (sym_end) begin
            bit_cnt <= cur_div - DIV_WIDTH'(1);
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state  <= StParity;
                tx_out <= par_bit;
              end else begin
                state  <= StStop;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx_out  <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - DIV_WIDTH'(1);
          end
        end
        StParity: begin
          if (sym_end) begin
            state   <= StStop;
            tx_out  <= 1'b1;
            bit_cnt <= cur_div - DIV_WIDTH'(1);
            bit_idx <= '0;
          end else begin
            bit_cnt <= bit_cnt - DIV_WIDTH'(1);
          end
        end
        StStop: begin
          if (sym_end) begin
            if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
              // Reaching here means no pop: either the FIFO is empty or a break is pending.
              state  <= StIdle;
              tx_out <= !brk_hold;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              bit_cnt <= cur_div - DIV_WIDTH'(1);
            end
          end else begin
            bit_cnt <= bit_cnt - DIV_WIDTH'(1);
          end
        end
        default: begin
          state  <= StIdle;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_uart_fifo.sv
// Scoreboard bench for tx_uart_fifo: three instances (8N1, 7E2, 7O2), stimulus pushes expected
// frames, per-instance monitors decode the serial line and compare against the reference frame.
module tb_tx_uart_fifo;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst_s;
  logic [N-1:0]       valid_s;
  logic [N-1:0]       div_we_s;
  logic [N-1:0]       tx_s;
  logic [N-1:0]       ready_s;
  logic [N-1:0]       busy_s;
  logic [N-1:0][8:0]  data_s;
  logic [N-1:0][15:0] div_s;
  logic [N-1:0][2:0]  cnt_s;

  int tests = 0;
  int fails = 0;
  int frames_done [N];
  bit [N-1:0] in_frame = '0;
  // Entry: {divisor[15:0], data[15:0]}
  logic [31:0] exp_q [N][$];

  tx_uart_fifo #(
    .SYSTEM_CLK(40), .BAUDRATE(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_DEPTH(4), .DIV_WIDTH(16)
  ) dut0 (
    .clk(clk), .reset(rst_s[0]), .valid(valid_s[0]), .tx_data(data_s[0][7:0]),
    .ready(ready_s[0]), .div_we(div_we_s[0]), .div_in(div_s[0]),
`ifdef TX_UART_BREAK_EN
    .brk(1'b0),
`endif
    .tx_out(tx_s[0]), .busy(busy_s[0]), .fifo_count(cnt_s[0])
  );

  tx_uart_fifo #(
    .SYSTEM_CLK(40), .BAUDRATE(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
    .FIFO_DEPTH(4), .DIV_WIDTH(16)
  ) dut1 (
    .clk(clk), .reset(rst_s[1]), .valid(valid_s[1]), .tx_data(data_s[1][6:0]),
    .ready(ready_s[1]), .div_we(div_we_s[1]), .div_in(div_s[1]),
`ifdef TX_UART_BREAK_EN
    .brk(1'b0),
`endif
    .tx_out(tx_s[1]), .busy(busy_s[1]), .fifo_count(cnt_s[1])
  );

  tx_uart_fifo #(
    .SYSTEM_CLK(40), .BAUDRATE(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
    .FIFO_DEPTH(4), .DIV_WIDTH(16)
  ) dut2 (
    .clk(clk), .reset(rst_s[2]), .valid(valid_s[2]), .tx_data(data_s[2][6:0]),
    .ready(ready_s[2]), .div_we(div_we_s[2]), .div_in(div_s[2]),
`ifdef TX_UART_BREAK_EN
    .brk(1'b0),
`endif
    .tx_out(tx_s[2]), .busy(busy_s[2]), .fifo_count(cnt_s[2])
  );

  function automatic int cfg_db(input int k);
    return (k == 0) ? 8 : 7;
  endfunction

  function automatic int cfg_par(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic int cfg_sb(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Reference frame: start 0, data LSB first, optional parity, stop ones.
  function automatic logic [15:0] frame_bits(input int k, input logic [8:0] d, output int nsym);
    logic [15:0] b;
    logic p;
    int n;
    b = '1;
    p = 1'b0;
    n = 0;
    b[n] = 1'b0;
    n++;
    for (int i = 0; i < cfg_db(k); i++) begin
      b[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (cfg_par(k) != 0) begin
      b[n] = (cfg_par(k) == 1) ? !p : p;
      n++;
    end
    nsym = n + cfg_sb(k);
    return b;
  endfunction

  task automatic monitor(input int k);
    logic [31:0] e;
    logic [15:0] bits;
    int nsym, dv, bad_s, bad_c;
    bit bad, aborted;
    logic bad_v;
    forever begin
      @(negedge clk);
      if (rst_s[k] === 1'b0 && tx_s[k] === 1'b0) begin
        if (exp_q[k].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame[%0d]: line low with nothing queued, want idle high", k);
          for (int w = 0; w < 64 && tx_s[k] !== 1'b1; w++) @(negedge clk);
        end else begin
          e = exp_q[k].pop_front();
          dv = int'(e[31:16]);
          bits = frame_bits(k, e[8:0], nsym);
          in_frame[k] = 1'b1;
          bad = 1'b0;
          aborted = 1'b0;
          bad_s = 0;
          bad_c = 0;
          bad_v = 1'b0;
          for (int s = 0; s < nsym && !aborted; s++) begin
            for (int c = 0; c < dv && !aborted; c++) begin
              if (s != 0 || c != 0) @(negedge clk);
              if (rst_s[k] === 1'b1) begin
                aborted = 1'b1;
              end else if (tx_s[k] !== bits[s] && !bad) begin
                bad = 1'b1;
                bad_s = s;
                bad_c = c;
                bad_v = tx_s[k];
              end
            end
          end
          in_frame[k] = 1'b0;
          if (!aborted) begin
            tests++;
            frames_done[k]++;
            if (bad) begin
              fails++;
              $display("FAIL frame[%0d] data=%h div=%0d: symbol %0d cycle %0d got %b, want %b",
                       k, e[8:0], dv, bad_s, bad_c, bad_v, bits[bad_s]);
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic put(input int k, input logic [8:0] d, input int dv, input bit acc);
    valid_s[k] = 1'b1;
    data_s[k]  = d;
    check($sformatf("ready_before_write[%0d] data=%h", k, d), int'(ready_s[k]), int'(acc));
    if (acc) exp_q[k].push_back({16'(dv), 16'(d)});
    tick();
    valid_s[k] = 1'b0;
  endtask

  task automatic set_div(input int k, input int v);
    div_we_s[k] = 1'b1;
    div_s[k]    = 16'(v);
    tick();
    div_we_s[k] = 1'b0;
  endtask

  task automatic measure_busy(input int k, input int start, input int exp, input string name);
    int n;
    n = start;
    while (busy_s[k] === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    check(name, n, exp);
  endtask

  task automatic wait_idle(input int k, input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || in_frame[k]) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_timeout: %0d frames still pending after %0d cycles, want 0",
               name, exp_q[k].size(), budget);
    end
    tick();
    check({name, "_busy_low"}, int'(busy_s[k]), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int base, n;
    logic [8:0] d;
    int dv;
    for (int k = 0; k < N; k++) frames_done[k] = 0;
    rst_s    = '1;
    valid_s  = '0;
    div_we_s = '0;
    data_s   = '0;
    div_s    = '0;
    repeat (3) tick();
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset_tx[%0d]", k), int'(tx_s[k]), 1);
      check($sformatf("reset_ready[%0d]", k), int'(ready_s[k]), 1);
      check($sformatf("reset_busy[%0d]", k), int'(busy_s[k]), 0);
      check($sformatf("reset_count[%0d]", k), int'(cnt_s[k]), 0);
    end
    rst_s = '0;
    tick();

    // 7E2 and 7O2 frames of 0x03: 11 symbols * 4 = 44 cycles, plus the queued cycle.
    put(1, 9'h03, 4, 1'b1);
    measure_busy(1, 0, 45, "busy_len_7e2");
    wait_idle(1, 200, "frame_7e2");
    put(2, 9'h03, 4, 1'b1);
    measure_busy(2, 0, 45, "busy_len_7o2");
    wait_idle(2, 200, "frame_7o2");

    // Single 8N1 frame: start bit appears one edge after acceptance.
    put(0, 9'h55, 4, 1'b1);
    check("latency_tx_at_accept", int'(tx_s[0]), 1);
    check("count_after_push", int'(cnt_s[0]), 1);
    tick();
    check("latency_tx_start", int'(tx_s[0]), 0);
    check("count_after_pop", int'(cnt_s[0]), 0);
    measure_busy(0, 1, 41, "busy_len_single");
    wait_idle(0, 200, "single");

    // Burst: second write coincides with the first pop, so the count holds at 1.
    put(0, 9'h01, 4, 1'b1);
    check("burst_count_1", int'(cnt_s[0]), 1);
    put(0, 9'h02, 4, 1'b1);
    check("burst_count_2", int'(cnt_s[0]), 1);
    put(0, 9'h03, 4, 1'b1);
    check("burst_count_3", int'(cnt_s[0]), 2);
    measure_busy(0, 2, 121, "busy_len_burst");
    wait_idle(0, 400, "burst");

    // Full FIFO: one word in flight plus four queued; the sixth write is dropped.
    base = frames_done[0];
    for (int i = 0; i < 6; i++) begin
      put(0, 9'(8'h10 + i), 4, i < 5);
      check($sformatf("full_count_%0d", i), int'(cnt_s[0]), (i == 0) ? 1 : ((i < 5) ? i : 4));
    end
    check("full_ready_low", int'(ready_s[0]), 0);
    wait_idle(0, 1000, "full");
    check("full_frames_sent", frames_done[0] - base, 5);

    // Divisor written mid-frame applies from the next frame; 1 clamps to 2.
    put(0, 9'hA5, 4, 1'b1);
    repeat (10) tick();
    set_div(0, 6);
    put(0, 9'h3C, 6, 1'b1);
    wait_idle(0, 400, "div_change");
    set_div(0, 1);
    put(0, 9'hC3, 2, 1'b1);
    wait_idle(0, 200, "div_clamp");

    // Randomised bursts with random divisors and gaps.
    for (int r = 0; r < 6; r++) begin
      dv = int'($urandom_range(2, 6));
      set_div(0, dv);
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        d = 9'($urandom_range(0, 255));
        put(0, d, dv, 1'b1);
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle(0, 2000, $sformatf("random_round_%0d", r));
    end

    // Reset during data bit 3 abandons the frame and the queued words.
    set_div(0, 4);
    base = frames_done[0];
    put(0, 9'h11, 4, 1'b1);
    put(0, 9'h22, 4, 1'b1);
    put(0, 9'h33, 4, 1'b1);
    repeat (16) tick();
    exp_q[0].delete();
    rst_s[0] = 1'b1;
    tick();
    check("midreset_tx", int'(tx_s[0]), 1);
    check("midreset_count", int'(cnt_s[0]), 0);
    check("midreset_busy", int'(busy_s[0]), 0);
    check("midreset_ready", int'(ready_s[0]), 1);
    rst_s[0] = 1'b0;
    repeat (200) tick();
    check("midreset_no_frames", frames_done[0] - base, 0);
    check("midreset_idle_tx", int'(tx_s[0]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
